// File: rtl/touch_panel_spi_pkg.sv
// Shared register map, status/control bit layout and frame-FSM states for the
// touch-panel SPI master and slave.
package touch_panel_spi_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int BIT_ROE  = 3;
    localparam int BIT_TOE  = 4;
    localparam int BIT_TUR  = 5;
    localparam int BIT_TRDY = 6;
    localparam int BIT_RRDY = 7;
    localparam int BIT_E    = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } frame_state_e;

    // Places the six flag/enable bits at their register positions.
    function automatic logic [15:0] pack_flags(input logic e, input logic rrdy,
                                               input logic trdy, input logic tur,
                                               input logic toe, input logic roe);
        logic [15:0] w;
        w           = '0;
        w[BIT_E]    = e;
        w[BIT_RRDY] = rrdy;
        w[BIT_TRDY] = trdy;
        w[BIT_TUR]  = tur;
        w[BIT_TOE]  = toe;
        w[BIT_ROE]  = roe;
        return w;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// N-stage synchronizer for an asynchronous SPI pin, with registered
// single-cycle rise/fall pulses (pin edge to pulse = STAGES+1 clk).
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;

    // The synchronizer chain carries the live pin value through reset, so a
    // pin that is already low never produces a false edge on reset release.
    always_ff @(posedge clk) begin
        sync_q  <= {sync_q[STAGES-2:0], pin};
        level_d <= sync_q[STAGES-1];
    end

    assign level = sync_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= level & ~level_d;
            fall <= ~level & level_d;
        end
    end

endmodule

// File: rtl/touch_panel_spi_slave.sv
// SPI mode-0 slave with CPU register port; far end of the touch-panel link.
// All SPI pins are oversampled in the clk domain.
module touch_panel_spi_slave
    import touch_panel_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam logic [15:0] CTRL_MASK = pack_flags(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_sync;
    logic ss_armed;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (SCLK),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (SS_n),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    always_ff @(posedge clk) begin
        mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    // After reset the bus is ignored until SS_n has been seen high again.
    always_ff @(posedge clk) begin
        if (reset)         ss_armed <= 1'b0;
        else if (ss_level) ss_armed <= 1'b1;
    end

    logic rd_cond, wr_cond, rd_cond_q, wr_cond_q, rd_stb, wr_stb;
    logic rd_rx, wr_tx, wr_st, wr_ctl;

    assign rd_cond = spi_select & ~read_n;
    assign wr_cond = spi_select & ~write_n;
    assign rd_stb  = rd_cond & ~rd_cond_q;
    assign wr_stb  = wr_cond & ~wr_cond_q;
    assign rd_rx   = rd_stb & (mem_addr == ADDR_RXDATA);
    assign wr_tx   = wr_stb & (mem_addr == ADDR_TXDATA);
    assign wr_st   = wr_stb & (mem_addr == ADDR_STATUS);
    assign wr_ctl  = wr_stb & (mem_addr == ADDR_CONTROL);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cond_q <= 1'b0;
            wr_cond_q <= 1'b0;
        end else begin
            rd_cond_q <= rd_cond;
            wr_cond_q <= wr_cond;
        end
    end

    frame_state_e state_q, state_d;
    logic [2:0]   bitcnt_q;
    logic         byte_done_q;
    logic         tx_load, byte_end, tx_shift_en, tx_accept;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        tx_load = 1'b0;
        case (state_q)
            IDLE:    if (ss_fall && ss_armed) state_d = LOAD;
            LOAD: begin
                tx_load = 1'b1;
                state_d = SHIFT;
            end
            SHIFT:   if (sclk_fall && bitcnt_q == 3'd0 && byte_done_q) tx_load = 1'b1;
            default: state_d = IDLE;
        endcase
        if (ss_rise) state_d = IDLE;
    end

    assign byte_end    = (state_q == SHIFT) & sclk_rise & (bitcnt_q == 3'd7);
    assign tx_shift_en = (state_q == SHIFT) & sclk_fall & ~tx_load;

    logic [7:0]  tx_shift_q, tx_hold_q, rx_shift_q, rx_hold_q;
    logic        tx_primed_q, rrdy_q, roe_q, toe_q, tur_q;
    logic [15:0] ctrl_q, status_w;

    // A load in the same cycle as a txdata write frees the holding register,
    // so the write is accepted rather than flagged as an overrun.
    assign tx_accept = ~tx_primed_q | tx_load;
    assign status_w  = pack_flags(roe_q | toe_q | tur_q, rrdy_q, ~tx_primed_q,
                                  tur_q, toe_q, roe_q);

    always_ff @(posedge clk) begin
        if (state_q == SHIFT && sclk_rise) rx_shift_q <= {rx_shift_q[6:0], mosi_sync};
        if (byte_end)                      rx_hold_q  <= {rx_shift_q[6:0], mosi_sync};
        if (wr_tx && tx_accept)            tx_hold_q  <= data_from_cpu[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt_q    <= 3'd0;
            byte_done_q <= 1'b0;
            tx_shift_q  <= 8'h00;
            tx_primed_q <= 1'b0;
            rrdy_q      <= 1'b0;
            roe_q       <= 1'b0;
            toe_q       <= 1'b0;
            tur_q       <= 1'b0;
            ctrl_q      <= 16'h0000;
            irq         <= 1'b0;
            data_to_cpu <= 16'h0000;
        end else begin
            if (state_q != SHIFT) begin
                bitcnt_q    <= 3'd0;
                byte_done_q <= 1'b0;
            end else if (sclk_rise) begin
                bitcnt_q <= bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) byte_done_q <= 1'b1;
            end

            if (tx_load)          tx_shift_q <= tx_primed_q ? tx_hold_q : FILL_BYTE;
            else if (tx_shift_en) tx_shift_q <= {tx_shift_q[6:0], 1'b0};

            if (wr_tx && tx_accept) tx_primed_q <= 1'b1;
            else if (tx_load)       tx_primed_q <= 1'b0;

            // Sets take priority over clears from the CPU.
            rrdy_q <= byte_end | (rrdy_q & ~rd_rx & ~wr_st);
            roe_q  <= (byte_end & rrdy_q) | (roe_q & ~wr_st);
            toe_q  <= (wr_tx & ~tx_accept) | (toe_q & ~wr_st);
            tur_q  <= (tx_load & ~tx_primed_q) | (tur_q & ~wr_st);

            if (wr_ctl) ctrl_q <= data_from_cpu & CTRL_MASK;
            irq <= |(status_w & ctrl_q);

            if (rd_stb) begin
                case (mem_addr)
                    ADDR_RXDATA:  data_to_cpu <= {8'h00, rx_hold_q};
                    ADDR_STATUS:  data_to_cpu <= status_w;
                    ADDR_CONTROL: data_to_cpu <= ctrl_q;
                    default:      data_to_cpu <= 16'h0000;
                endcase
            end
        end
    end

    assign MISO          = tx_shift_q[7];
    assign MISO_oe       = ~ss_level & ss_armed;
    assign dataavailable = rrdy_q;
    assign readyfordata  = ~tx_primed_q;

endmodule
